dcache_snoop_ctrl: RTL and testbench

Snoop initiator for the data-cache tag copy. It accepts coherence snoop requests from the peer core's bus and drives the snoop read port of the dual tag store, which is bank 2's port A (`addr_a2` / `data_out_a2`). It compares the returned tag, and on a hit with invalidate intent it requests an invalidating tag write through the local cache's port-A arbitration. A one-cycle hit/miss response goes back to the requester.

---
 rtl/dcache_snoop_ctrl_pkg.sv | 34 +++
 rtl/dcache_snoop_ctrl_fifo.sv | 69 ++++++
 rtl/dcache_snoop_ctrl.sv | 142 ++++++++++++++
 tb/tb_dcache_snoop_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_snoop_ctrl_pkg.sv
// Shared data-cache types for the snoop controller: tag-entry layout,
// buffered snoop request record and the snoop FSM state encoding.
package dcache_snoop_ctrl_pkg;

  localparam int DC_ADDR_W     = 32;
  localparam int DC_LINES      = 512;
  localparam int DC_IDX_W      = $clog2(DC_LINES);
  localparam int DC_LINE_WORDS = 4;
  localparam int DC_OFF_W      = $clog2(DC_LINE_WORDS) + 2;
  localparam int DC_TAG_W      = DC_ADDR_W - DC_IDX_W - DC_OFF_W;

  typedef struct packed {
    logic                valid;
    logic [DC_TAG_W-1:0] tag;
  } dtag_entry_t;

  localparam int SNOOP_ENTRY_W = $bits(dtag_entry_t);

  typedef struct packed {
    logic [DC_ADDR_W-1:0] addr;
    logic                 inv;
  } snoop_req_t;

  localparam int SNOOP_REQ_W = $bits(snoop_req_t);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_COMPARE = 3'd2,
    ST_INVAL   = 3'd3,
    ST_RESP    = 3'd4
  } snoop_state_t;

endpackage

// File: rtl/dcache_snoop_ctrl_fifo.sv
// Synchronous FIFO of snoop requests; full/empty are registered flags and a
// push into an empty buffer becomes visible on the following cycle.
module snoop_req_fifo
  import dcache_snoop_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  snoop_req_t wdata,
  output snoop_req_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  snoop_req_t             mem_r [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   full_r;
  logic                   empty_r;
  logic                   push_s;
  logic                   pop_s;

  assign push_s = push & ~full_r;
  assign pop_s  = pop & ~empty_r;
  assign rdata  = mem_r[rd_ptr_r];
  assign full   = full_r;
  assign empty  = empty_r;

  // Occupancy update.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Pointers, count and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      cnt_r   <= cnt_nxt_s;
      full_r  <= (cnt_nxt_s == CNT_W'(DEPTH));
      empty_r <= (cnt_nxt_s == {CNT_W{1'b0}});
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/dcache_snoop_ctrl.sv
// Snoop initiator for the dual data-cache tag store (bank 2 port A).
// Optional hit counter port enabled by `DCACHE_SNOOP_STATS_EN.
module dcache_snoop_ctrl
  import dcache_snoop_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINES      = 512,
  parameter int IDX_W      = $clog2(LINES),
  parameter int LINE_WORDS = 4,
  parameter int OFF_W      = $clog2(LINE_WORDS) + 2,
  parameter int TAG_W      = ADDR_W - IDX_W - OFF_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snoop_valid,
  output logic              snoop_ready,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              snoop_inv,
  output logic [IDX_W-1:0]  snoop_tag_addr,
  input  logic [TAG_W:0]    snoop_tag_data,
  input  logic              local_tag_wen,
  input  logic [IDX_W-1:0]  local_tag_addr,
  output logic              inv_req,
  output logic [IDX_W-1:0]  inv_addr,
  input  logic              inv_ack,
  output logic              resp_valid,
  output logic              resp_hit
`ifdef DCACHE_SNOOP_STATS_EN
  ,
  output logic [31:0]       hit_count
`endif
);

  snoop_state_t     state_r;
  snoop_state_t     state_nxt_s;
  snoop_req_t       work_r;
  snoop_req_t       push_req_s;
  snoop_req_t       fifo_head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             pop_s;
  logic             hit_s;
  logic             hit_r;
  logic [IDX_W-1:0] work_idx_s;
  logic [IDX_W-1:0] head_idx_s;
  logic [TAG_W-1:0] work_tag_s;
  logic             unused_off_s;

  assign push_req_s   = {snoop_addr, snoop_inv};
  assign snoop_ready  = ~fifo_full_s;
  assign work_idx_s   = work_r.addr[OFF_W +: IDX_W];
  assign head_idx_s   = fifo_head_s.addr[OFF_W +: IDX_W];
  assign work_tag_s   = work_r.addr[ADDR_W-1 -: TAG_W];
  assign hit_s        = snoop_tag_data[TAG_W] & (snoop_tag_data[TAG_W-1:0] == work_tag_s);
  assign unused_off_s = ^{work_r.addr[OFF_W-1:0], fifo_head_s.addr[OFF_W-1:0],
                          fifo_head_s.addr[ADDR_W-1 -: TAG_W], fifo_head_s.inv};

  snoop_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (snoop_valid & snoop_ready),
    .pop   (pop_s),
    .wdata (push_req_s),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state logic for the snoop sequencer.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_LOOKUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        // A local write owns the port this cycle, so the read is lost.
        if (!local_tag_wen) state_nxt_s = ST_COMPARE;
        else                state_nxt_s = ST_LOOKUP;
      end
      ST_COMPARE: begin
        if (local_tag_wen && (local_tag_addr == work_idx_s)) state_nxt_s = ST_LOOKUP;
        else if (hit_s && work_r.inv)                        state_nxt_s = ST_INVAL;
        else                                                 state_nxt_s = ST_RESP;
      end
      ST_INVAL: begin
        if (inv_ack) state_nxt_s = ST_RESP;
        else         state_nxt_s = ST_INVAL;
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, working request and registered outputs aligned with the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      work_r         <= {SNOOP_REQ_W{1'b0}};
      hit_r          <= 1'b0;
      snoop_tag_addr <= {IDX_W{1'b0}};
      inv_req        <= 1'b0;
      inv_addr       <= {IDX_W{1'b0}};
      resp_valid     <= 1'b0;
      resp_hit       <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (pop_s) begin
        work_r         <= fifo_head_s;
        snoop_tag_addr <= head_idx_s;
      end
      if (state_r == ST_COMPARE) hit_r <= hit_s;
      inv_req <= (state_nxt_s == ST_INVAL);
      if (state_nxt_s == ST_INVAL) inv_addr <= work_idx_s;
      resp_valid <= (state_nxt_s == ST_RESP);
      resp_hit   <= (state_nxt_s == ST_RESP) & ((state_r == ST_COMPARE) ? hit_s : hit_r);
    end
  end

`ifdef DCACHE_SNOOP_STATS_EN
  // Hit counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count <= 32'd0;
    end else if ((state_r == ST_RESP) && resp_hit) begin
      hit_count <= hit_count + 32'd1;
    end else begin
      hit_count <= hit_count;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_snoop_ctrl.sv
// Self-checking bench for dcache_snoop_ctrl: directed vector table, FIFO and
// reset sequences, and randomized traffic against an in-order lookup model.
module tb_dcache_snoop_ctrl;
  import dcache_snoop_ctrl_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LINES  = 512;
  localparam int IDX_W  = 9;
  localparam int OFF_W  = 4;
  localparam int TAG_W  = 19;
  localparam int ENT_W  = 20;
  localparam int NRND   = 80;

  logic              clk;
  logic              rst;
  logic              snoop_valid;
  logic              snoop_ready;
  logic [ADDR_W-1:0] snoop_addr;
  logic              snoop_inv;
  logic [IDX_W-1:0]  snoop_tag_addr;
  logic [ENT_W-1:0]  snoop_tag_data;
  logic              local_tag_wen;
  logic [IDX_W-1:0]  local_tag_addr;
  logic              inv_req;
  logic [IDX_W-1:0]  inv_addr;
  logic              inv_ack;
  logic              resp_valid;
  logic              resp_hit;
`ifdef DCACHE_SNOOP_STATS_EN
  logic [31:0]       hit_count;
`endif

  int checks = 0;
  int errors = 0;

  dcache_snoop_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .snoop_valid    (snoop_valid),
    .snoop_ready    (snoop_ready),
    .snoop_addr     (snoop_addr),
    .snoop_inv      (snoop_inv),
    .snoop_tag_addr (snoop_tag_addr),
    .snoop_tag_data (snoop_tag_data),
    .local_tag_wen  (local_tag_wen),
    .local_tag_addr (local_tag_addr),
    .inv_req        (inv_req),
    .inv_addr       (inv_addr),
    .inv_ack        (inv_ack),
    .resp_valid     (resp_valid),
    .resp_hit       (resp_hit)
`ifdef DCACHE_SNOOP_STATS_EN
    ,
    .hit_count      (hit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag store model: one-cycle read, reads corrupted while a local write steals the port.
  logic [ENT_W-1:0] mem [LINES];
  logic             pre_en;
  logic [IDX_W-1:0] pre_idx;
  logic [ENT_W-1:0] pre_data;
  logic [ENT_W-1:0] local_wdata;
  logic             local_keep;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LINES; i++) mem[i] <= '0;
    end else begin
      if (pre_en) mem[pre_idx] <= pre_data;
      if (local_tag_wen && !local_keep) mem[local_tag_addr] <= local_wdata;
      if (inv_ack && inv_req) mem[inv_addr][TAG_W] <= 1'b0;
    end
    snoop_tag_data <= local_tag_wen ? ~mem[snoop_tag_addr] : mem[snoop_tag_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; snoop_valid = 1'b0; snoop_addr = '0; snoop_inv = 1'b0;
    local_tag_wen = 1'b0; local_tag_addr = '0; local_wdata = '0; local_keep = 1'b0;
    inv_ack = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic preload(input logic [IDX_W-1:0] idx, input logic [ENT_W-1:0] data);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // One snoop from offer to response; lat counts cycles after the accept cycle.
  task automatic run_snoop(input logic [31:0] addr, input logic inv, input int st_start,
                           input int st_len, input logic [IDX_W-1:0] st_idx,
                           input logic [ENT_W-1:0] st_data, input int ack_dly,
                           output int lat, output logic hit, output logic saw_inv);
    int ack_cnt;
    logic [IDX_W-1:0] idx;
    idx = addr[OFF_W +: IDX_W];
    lat = -1; hit = 1'b0; saw_inv = 1'b0; ack_cnt = 0;
    @(negedge clk);
    snoop_valid = 1'b1; snoop_addr = addr; snoop_inv = inv;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      snoop_valid = 1'b0;
      inv_ack = 1'b0;
      if (resp_valid) begin
        lat = c; hit = resp_hit;
        break;
      end
      if (inv_req) begin
        if (!saw_inv) check("inv_addr", 32'(inv_addr), 32'(idx));
        saw_inv = 1'b1;
        if (ack_cnt >= ack_dly) inv_ack = 1'b1;
        ack_cnt++;
      end
      local_tag_wen  = (st_len > 0) && (c >= st_start) && (c < st_start + st_len);
      local_tag_addr = st_idx;
      local_wdata    = st_data;
    end
    local_tag_wen = 1'b0;
    inv_ack = 1'b0;
  endtask

  typedef struct {
    string            name;
    logic [31:0]      addr;
    logic             inv;
    logic [ENT_W-1:0] entry;
    int               st_start;
    int               st_len;
    logic [IDX_W-1:0] st_idx;
    logic [ENT_W-1:0] st_data;
    int               ack_dly;
    int               exp_lat;
    logic             exp_hit;
    logic             exp_inv;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        inv;
    int          k;
  } rq_t;

  vec_t             vecs [14];
  rq_t              q [$];
  logic [IDX_W-1:0] idx_set [16];
  logic [ENT_W-1:0] model_ent [16];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic hit;
    logic saw;
    logic exp_h;
    int   got;
    int   sent;
    logic inv_seen;
    logic [2:0] exp_seq;

    // name, addr, inv, entry, steal start/len/idx/data, ack delay, latency, hit, inv
    vecs[0]  = '{"inv_hit",        32'h0000_1230, 1'b1, 20'h80000, 0, 0, 9'h000, 20'h00000, 0, 5, 1'b1, 1'b1};
    vecs[1]  = '{"probe_hit",      32'h0000_1230, 1'b0, 20'h80000, 0, 0, 9'h000, 20'h00000, 0, 4, 1'b1, 1'b0};
    vecs[2]  = '{"invalid_entry",  32'h0000_1230, 1'b1, 20'h00000, 0, 0, 9'h000, 20'h00000, 0, 4, 1'b0, 1'b0};
    vecs[3]  = '{"lookup_steal3",  32'hABCD_E5F0, 1'b0, 20'hD5E6F, 2, 3, 9'h1FF, 20'h00000, 0, 7, 1'b1, 1'b0};
    vecs[4]  = '{"tag_mismatch",   32'hABCD_E5F0, 1'b1, 20'hD5E6E, 0, 0, 9'h000, 20'h00000, 0, 4, 1'b0, 1'b0};
    vecs[5]  = '{"inv_ack_late",   32'hABCD_E5F0, 1'b1, 20'hD5E6F, 0, 0, 9'h000, 20'h00000, 3, 8, 1'b1, 1'b1};
    vecs[6]  = '{"cmp_other_idx",  32'hABCD_E5F0, 1'b0, 20'hD5E6F, 3, 1, 9'h1FF, 20'h00000, 0, 4, 1'b1, 1'b0};
    vecs[7]  = '{"cmp_same_keep",  32'hABCD_E5F0, 1'b0, 20'hD5E6F, 3, 1, 9'h05F, 20'hD5E6F, 0, 6, 1'b1, 1'b0};
    vecs[8]  = '{"cmp_same_upd",   32'hABCD_E5F0, 1'b0, 20'hD5E6F, 3, 1, 9'h05F, 20'h55E6F, 0, 6, 1'b0, 1'b0};
    vecs[9]  = '{"lookup_same_upd",32'hABCD_E5F0, 1'b0, 20'hD5E6E, 2, 1, 9'h05F, 20'hD5E6F, 0, 5, 1'b1, 1'b0};
    vecs[10] = '{"inval_local_wr", 32'hABCD_E5F0, 1'b1, 20'hD5E6F, 4, 2, 9'h05F, 20'hD5E6F, 2, 7, 1'b1, 1'b1};
    vecs[11] = '{"idx_max_inv",    32'hFFFF_FFF0, 1'b1, 20'hFFFFF, 0, 0, 9'h000, 20'h00000, 0, 5, 1'b1, 1'b1};
    vecs[12] = '{"idx0_miss",      32'h0000_200C, 1'b0, 20'h80002, 0, 0, 9'h000, 20'h00000, 0, 4, 1'b0, 1'b0};
    vecs[13] = '{"idx0_inv_hit",   32'h0000_200C, 1'b1, 20'h80001, 0, 0, 9'h000, 20'h00000, 0, 5, 1'b1, 1'b1};

    // Reset values, sampled while reset is held.
    rst = 1'b0; snoop_valid = 1'b0; snoop_addr = '0; snoop_inv = 1'b0;
    local_tag_wen = 1'b0; local_tag_addr = '0; local_wdata = '0; local_keep = 1'b0;
    inv_ack = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_snoop_ready", 32'(snoop_ready), 32'd1);
    check("rst_inv_req", 32'(inv_req), 32'd0);
    check("rst_inv_addr", 32'(inv_addr), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_hit", 32'(resp_hit), 32'd0);
    check("rst_tag_addr", 32'(snoop_tag_addr), 32'd0);
`ifdef DCACHE_SNOOP_STATS_EN
    check("rst_hit_count", hit_count, 32'd0);
`endif
    do_reset();

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      preload(vecs[i].addr[OFF_W +: IDX_W], vecs[i].entry);
      run_snoop(vecs[i].addr, vecs[i].inv, vecs[i].st_start, vecs[i].st_len, vecs[i].st_idx,
                vecs[i].st_data, vecs[i].ack_dly, lat, hit, saw);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      check({vecs[i].name, "_hit"}, 32'(hit), 32'(vecs[i].exp_hit));
      check({vecs[i].name, "_inv"}, 32'(saw), 32'(vecs[i].exp_inv));
      repeat (2) @(negedge clk);
    end

    // Back-to-back snoops into a two-entry buffer; responses must stay in order.
    do_reset();
    preload(9'h123, 20'h80000);
    preload(9'h05F, 20'hD5E6E);
    preload(9'h1FF, 20'hFFFFF);
    @(negedge clk);
    snoop_valid = 1'b1; snoop_inv = 1'b0; snoop_addr = 32'h0000_1230;
    check("fifo_ready_0", 32'(snoop_ready), 32'd1);
    @(negedge clk);
    snoop_addr = 32'hABCD_E5F0;
    check("fifo_ready_1", 32'(snoop_ready), 32'd1);
    @(negedge clk);
    snoop_addr = 32'hFFFF_FFF0;
    check("fifo_ready_2", 32'(snoop_ready), 32'd1);
    @(negedge clk);
    snoop_valid = 1'b0;
    check("fifo_ready_full", 32'(snoop_ready), 32'd0);
    exp_seq = 3'b101;
    got = 0;
    for (int c = 0; c < 60; c++) begin
      if (resp_valid) begin
        if (got < 3) check("fifo_order_hit", 32'(resp_hit), 32'(exp_seq[got]));
        got++;
      end
      @(negedge clk);
    end
    check("fifo_resp_count", 32'(got), 32'd3);
    check("fifo_ready_drained", 32'(snoop_ready), 32'd1);
`ifdef DCACHE_SNOOP_STATS_EN
    check("hit_count", hit_count, 32'd2);
`endif

    // Reset while an invalidate is pending.
    preload(9'h123, 20'h80000);
    @(negedge clk);
    snoop_valid = 1'b1; snoop_addr = 32'h0000_1230; snoop_inv = 1'b1;
    @(negedge clk);
    snoop_valid = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 20 && !saw; c++) begin
      @(negedge clk);
      saw = inv_req;
    end
    check("mid_rst_inv_seen", 32'(saw), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_inv_drop", 32'(inv_req), 32'd0);
    check("mid_rst_ready", 32'(snoop_ready), 32'd1);
    rst = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (resp_valid || inv_req) got++;
    end
    check("mid_rst_quiet", 32'(got), 32'd0);

    // Randomized traffic against an in-order lookup model.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      idx_set[k]   = IDX_W'(k * 31 + 5);
      model_ent[k] = {($urandom_range(3) != 0), TAG_W'($urandom)};
      preload(idx_set[k], model_ent[k]);
    end
    local_keep = 1'b1;
    sent = 0; got = 0; inv_seen = 1'b0;
    for (int cyc = 0; cyc < 20000 && got < NRND; cyc++) begin
      @(negedge clk);
      inv_ack = 1'b0;
      if (resp_valid) begin
        if (q.size() == 0) begin
          check("rnd_spurious_resp", 32'd1, 32'd0);
        end else begin
          exp_h = model_ent[q[0].k][TAG_W] &&
                  (model_ent[q[0].k][TAG_W-1:0] == q[0].addr[ADDR_W-1 -: TAG_W]);
          check("rnd_hit", 32'(resp_hit), 32'(exp_h));
          check("rnd_inv", 32'(inv_seen), 32'(exp_h && q[0].inv));
          if (exp_h && q[0].inv) model_ent[q[0].k][TAG_W] = 1'b0;
          void'(q.pop_front());
        end
        got++;
        inv_seen = 1'b0;
      end
      if (inv_req) begin
        if (!inv_seen && q.size() > 0)
          check("rnd_inv_addr", 32'(inv_addr), 32'(idx_set[q[0].k]));
        inv_seen = 1'b1;
        inv_ack = ($urandom_range(2) == 0);
      end
      local_tag_wen  = ($urandom_range(3) == 0);
      local_tag_addr = ($urandom_range(1) == 0) ? idx_set[$urandom_range(15)] : IDX_W'($urandom);
      if (sent < NRND) begin
        rq_t r;
        r.k    = $urandom_range(15);
        r.inv  = $urandom_range(1) == 1;
        r.addr = {(($urandom_range(2) == 0) ? TAG_W'($urandom) : model_ent[r.k][TAG_W-1:0]),
                  idx_set[r.k], 4'($urandom)};
        snoop_valid = ($urandom_range(1) == 1);
        snoop_addr  = r.addr;
        snoop_inv   = r.inv;
        if (snoop_valid && snoop_ready) begin
          q.push_back(r);
          sent++;
        end
      end else begin
        snoop_valid = 1'b0;
      end
    end
    snoop_valid = 1'b0; local_tag_wen = 1'b0; inv_ack = 1'b0;
    check("rnd_all_responded", 32'(got), 32'(NRND));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
